// File: rtl/disp_pixel_fifo.sv
// Single-clock pixel FIFO: packed multi-pixel words in, one pixel per cycle out.
// Includes flush, watermark ready, fill-colour on underflow, word drop on overflow and sticky flags.
module disp_pixel_fifo #(
  parameter int              PIX_W      = 24,
  parameter int              LANE_W     = 32,
  parameter int              PPW        = 2,
  parameter int              DEPTH_LOG2 = 10,
  parameter int              WMARK      = 300,
  parameter logic [PIX_W-1:0] FILL_PIX  = 24'h000000
) (
  input  logic                  ACLK,
  input  logic                  ARSTN,
  input  logic                  FLUSH,
  input  logic                  CLR_ERR,
  input  logic [PPW*LANE_W-1:0] FIFOIN,
  input  logic                  FIFOWR,
  input  logic                  DISPON,
  input  logic                  DSP_preDE,
  output logic                  BUF_WREADY,
  output logic                  BUF_OVER,
  output logic                  BUF_UNDER,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic [PIX_W-1:0]      DSP_PIX,
  output logic                  DSP_DE
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef logic [LW-1:0]         lvl_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef struct packed {
    logic             de;
    logic [PIX_W-1:0] pix;
  } out_t;

  localparam lvl_t DEPTH_L = lvl_t'(DEPTH);
  localparam lvl_t PPW_L   = lvl_t'(PPW);
  localparam lvl_t WMARK_L = lvl_t'(WMARK);

  logic [PIX_W-1:0]            mem [DEPTH];
  logic [PPW-1:0][PIX_W-1:0]   lane_pix;
  ptr_t                        wp, rp;
  lvl_t                        level, level_nxt;
  out_t                        out_q, out_nxt;
  logic                        rd_req, empty, fits;
  logic                        wr_ok, ovf_evt, rd_ok, unf_evt;
  logic                        unused_in;

  for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
    assign lane_pix[gi] = FIFOIN[gi*LANE_W +: PIX_W];
  end

  // Lane padding bits above PIX_W carry no data.
  assign unused_in = ^FIFOIN;

  assign rd_req  = DSP_preDE & DISPON;
  assign empty   = (level == '0);
  assign fits    = (DEPTH_L - level) >= PPW_L;
  assign wr_ok   = FIFOWR & fits & ~FLUSH;
  assign ovf_evt = FIFOWR & ~fits & ~FLUSH;
  assign rd_ok   = rd_req & ~empty & ~FLUSH;
  assign unf_evt = rd_req & empty & ~FLUSH;

  always_comb begin
    level_nxt = level;
    if (wr_ok) level_nxt = level_nxt + PPW_L;
    if (rd_ok) level_nxt = level_nxt - lvl_t'(1);
  end

  // Flush turns any concurrent read into a fill pixel; blanking wins over both.
  always_comb begin
    out_nxt.de  = DSP_preDE;
    out_nxt.pix = '0;
    if (rd_req) out_nxt.pix = (FLUSH || empty) ? FILL_PIX : mem[rp];
  end

  always_ff @(posedge ACLK) begin
    for (int k = 0; k < PPW; k++)
      if (wr_ok) mem[wp + ptr_t'(k)] <= lane_pix[k];
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      BUF_OVER  <= 1'b0;
      BUF_UNDER <= 1'b0;
      out_q     <= '0;
    end else begin
      out_q <= out_nxt;
      if (FLUSH) begin
        wp        <= '0;
        rp        <= '0;
        level     <= '0;
        BUF_OVER  <= 1'b0;
        BUF_UNDER <= 1'b0;
      end else begin
        if (wr_ok) wp <= wp + ptr_t'(PPW);
        if (rd_ok) rp <= rp + ptr_t'(1);
        level     <= level_nxt;
        BUF_OVER  <= (BUF_OVER  & ~CLR_ERR) | ovf_evt;
        BUF_UNDER <= (BUF_UNDER & ~CLR_ERR) | unf_evt;
      end
    end
  end

  assign BUF_WREADY = (level <= WMARK_L);
  assign LEVEL      = level;
  assign DSP_PIX    = out_q.pix;
  assign DSP_DE     = out_q.de;
endmodule

// File: tb/tb_disp_pixel_fifo.sv
// Bench for disp_pixel_fifo: queue-based reference model, directed scenarios plus random traffic.
module tb_disp_pixel_fifo;
  localparam int PIX_W = 24, LANE_W = 32, PPW = 2, DL2 = 4, WMARK = 8;
  localparam int DEPTH = 1 << DL2;
  localparam int LW = DL2 + 1;
  localparam int WW = PPW * LANE_W;
  localparam logic [PIX_W-1:0] FILL = 24'h0000FF;

  logic            ACLK = 1'b0, ARSTN = 1'b0;
  logic            FLUSH = 0, CLR_ERR = 0, FIFOWR = 0, DISPON = 0, DSP_preDE = 0;
  logic [WW-1:0]   FIFOIN = '0;
  logic            BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE;
  logic [LW-1:0]   LEVEL;
  logic [PIX_W-1:0] DSP_PIX;

  int checks = 0, errors = 0;

  logic [PIX_W-1:0] q[$];
  logic [PIX_W-1:0] exp_pix = '0;
  logic             exp_de = 0, exp_over = 0, exp_under = 0;

  disp_pixel_fifo #(.PIX_W(PIX_W), .LANE_W(LANE_W), .PPW(PPW), .DEPTH_LOG2(DL2),
                    .WMARK(WMARK), .FILL_PIX(FILL)) dut (
    .ACLK(ACLK), .ARSTN(ARSTN), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR), .FIFOIN(FIFOIN),
    .FIFOWR(FIFOWR), .DISPON(DISPON), .DSP_preDE(DSP_preDE), .BUF_WREADY(BUF_WREADY),
    .BUF_OVER(BUF_OVER), .BUF_UNDER(BUF_UNDER), .LEVEL(LEVEL), .DSP_PIX(DSP_PIX),
    .DSP_DE(DSP_DE));

  always #5 ACLK = ~ACLK;

  function automatic logic [WW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle of inputs, advance the model by the block's rules, return at edge+1.
  task automatic cycle(input logic fl, input logic clr, input logic wr, input logic [WW-1:0] w,
                       input logic de, input logic on);
    bit emp, acc;
    FLUSH = fl; CLR_ERR = clr; FIFOWR = wr; FIFOIN = w; DSP_preDE = de; DISPON = on;
    emp = (q.size() == 0);
    acc = wr && !fl && ((DEPTH - q.size()) >= PPW);
    exp_de = de;
    if (!de || !on)     exp_pix = '0;
    else if (fl || emp) exp_pix = FILL;
    else                exp_pix = q.pop_front();
    if (fl) begin
      q.delete(); exp_over = 0; exp_under = 0;
    end else begin
      exp_over  = (exp_over  & !clr) | (wr & !acc);
      exp_under = (exp_under & !clr) | (de & on & emp);
      if (acc) for (int k = 0; k < PPW; k++) q.push_back(w[k*LANE_W +: PIX_W]);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    #8;
    checks++;
    if (LEVEL !== '0 || BUF_WREADY !== 1'b1 || BUF_OVER !== 1'b0 || BUF_UNDER !== 1'b0 ||
        DSP_DE !== 1'b0 || DSP_PIX !== '0) begin
      errors++;
      $display("FAIL reset: LEVEL=%0d WREADY=%b OVER=%b UNDER=%b DE=%b PIX=%h, required 0 1 0 0 0 000000",
               LEVEL, BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE, DSP_PIX);
    end
    #4 ARSTN = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_basic();
    logic [PIX_W-1:0] want [3];
    logic [WW-1:0] w;
    want[0] = 24'hBB0000; want[1] = 24'hAA0000; want[2] = FILL;
    w = 64'h00AA0000_00BB0000;
    cycle(0, 0, 1, w, 0, 0);
    checks++;
    if (DSP_DE !== 1'b0 || LEVEL !== LW'(2)) begin
      errors++; $display("FAIL basic_write: DE=%b LEVEL=%0d, required 0 2", DSP_DE, LEVEL);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, '0, 1, 1);
      checks++;
      if (DSP_DE !== 1'b1 || DSP_PIX !== want[i]) begin
        errors++; $display("FAIL basic_pix%0d: DE=%b PIX=%h, required 1 %h", i, DSP_DE, DSP_PIX, want[i]);
      end
    end
    checks++;
    if (BUF_UNDER !== 1'b1 || BUF_OVER !== 1'b0) begin
      errors++; $display("FAIL basic_under: UNDER=%b OVER=%b, required 1 0", BUF_UNDER, BUF_OVER);
    end
    cycle(0, 1, 0, '0, 0, 0);
    checks++;
    if (BUF_UNDER !== 1'b0 || DSP_DE !== 1'b0 || DSP_PIX !== '0) begin
      errors++; $display("FAIL basic_clr: UNDER=%b DE=%b PIX=%h, required 0 0 000000", BUF_UNDER, DSP_DE, DSP_PIX);
    end
  endtask

  // Pointers start offset by the earlier reads, so 16 pixels wrap the array.
  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, rand_word(), 0, 0);
      checks++;
      if (LEVEL !== LW'(2*(i+1)) || BUF_WREADY !== (2*(i+1) <= WMARK)) begin
        errors++; $display("FAIL ovf_fill%0d: LEVEL=%0d WREADY=%b, required %0d %b",
                           i, LEVEL, BUF_WREADY, 2*(i+1), (2*(i+1) <= WMARK));
      end
    end
    cycle(0, 0, 1, rand_word(), 0, 0);
    checks++;
    if (LEVEL !== LW'(16) || BUF_OVER !== 1'b1 || BUF_WREADY !== 1'b0) begin
      errors++; $display("FAIL ovf_drop: LEVEL=%0d OVER=%b WREADY=%b, required 16 1 0", LEVEL, BUF_OVER, BUF_WREADY);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, '0, 1, 1);
      checks++;
      if (DSP_PIX !== exp_pix || LEVEL !== LW'(15 - i)) begin
        errors++; $display("FAIL ovf_read%0d: PIX=%h LEVEL=%0d, required %h %0d", i, DSP_PIX, LEVEL, exp_pix, 15 - i);
      end
    end
    cycle(0, 1, 0, '0, 0, 0);
    checks++;
    if (BUF_OVER !== 1'b0 || BUF_UNDER !== 1'b0) begin
      errors++; $display("FAIL ovf_clr: OVER=%b UNDER=%b, required 0 0", BUF_OVER, BUF_UNDER);
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, rand_word(), 0, 0);
    checks++;
    if (LEVEL !== LW'(6)) begin
      errors++; $display("FAIL conc_pre: LEVEL=%0d, required 6", LEVEL);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, rand_word(), 1, 1);
      checks++;
      if (LEVEL !== LW'(7 + i) || BUF_WREADY !== ((7 + i) <= WMARK) || DSP_PIX !== exp_pix) begin
        errors++; $display("FAIL conc%0d: LEVEL=%0d WREADY=%b PIX=%h, required %0d %b %h",
                           i, LEVEL, BUF_WREADY, DSP_PIX, 7 + i, ((7 + i) <= WMARK), exp_pix);
      end
    end
    while (q.size() > 0) begin
      cycle(0, 0, 0, '0, 1, 1);
      checks++;
      if (DSP_PIX !== exp_pix) begin
        errors++; $display("FAIL conc_drain: PIX=%h, required %h", DSP_PIX, exp_pix);
      end
    end
  endtask

  task automatic test_flush();
    cycle(0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, rand_word(), 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0, '0, 1, 1);
    checks++;
    if (LEVEL !== LW'(5) || BUF_OVER !== 1'b1 || BUF_UNDER !== 1'b1) begin
      errors++; $display("FAIL flush_pre: LEVEL=%0d OVER=%b UNDER=%b, required 5 1 1", LEVEL, BUF_OVER, BUF_UNDER);
    end
    cycle(1, 0, 1, rand_word(), 1, 1);
    checks++;
    if (LEVEL !== '0 || BUF_OVER !== 1'b0 || BUF_UNDER !== 1'b0 || DSP_PIX !== FILL || DSP_DE !== 1'b1) begin
      errors++; $display("FAIL flush: LEVEL=%0d OVER=%b UNDER=%b PIX=%h DE=%b, required 0 0 0 %h 1",
                         LEVEL, BUF_OVER, BUF_UNDER, DSP_PIX, DSP_DE, FILL);
    end
  endtask

  task automatic test_blank();
    cycle(0, 0, 1, rand_word(), 0, 0);
    cycle(0, 0, 1, rand_word(), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, '0, 1, 0);
      checks++;
      if (DSP_DE !== 1'b1 || DSP_PIX !== '0 || LEVEL !== LW'(4) || BUF_UNDER !== 1'b0) begin
        errors++; $display("FAIL blank%0d: DE=%b PIX=%h LEVEL=%0d UNDER=%b, required 1 000000 4 0",
                           i, DSP_DE, DSP_PIX, LEVEL, BUF_UNDER);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
            rand_word(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 9));
      checks++;
      if (LEVEL !== LW'(q.size()) || DSP_PIX !== exp_pix || DSP_DE !== exp_de ||
          BUF_OVER !== exp_over || BUF_UNDER !== exp_under || BUF_WREADY !== (q.size() <= WMARK)) begin
        errors++;
        $display("FAIL rand%0d: LEVEL=%0d PIX=%h DE=%b OVER=%b UNDER=%b WREADY=%b, required %0d %h %b %b %b %b",
                 i, LEVEL, DSP_PIX, DSP_DE, BUF_OVER, BUF_UNDER, BUF_WREADY,
                 q.size(), exp_pix, exp_de, exp_over, exp_under, (q.size() <= WMARK));
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, rand_word(), 0, 0);
    cycle(0, 0, 0, '0, 1, 1);
    checks++;
    if (LEVEL !== LW'(7) || DSP_DE !== 1'b1 || DSP_PIX !== exp_pix) begin
      errors++; $display("FAIL arst_pre: LEVEL=%0d DE=%b PIX=%h, required 7 1 %h", LEVEL, DSP_DE, DSP_PIX, exp_pix);
    end
    #2 ARSTN = 1'b0;
    #1;
    checks++;
    if (LEVEL !== '0 || BUF_WREADY !== 1'b1 || BUF_OVER !== 1'b0 || BUF_UNDER !== 1'b0 ||
        DSP_DE !== 1'b0 || DSP_PIX !== '0) begin
      errors++; $display("FAIL arst_async: LEVEL=%0d WREADY=%b OVER=%b UNDER=%b DE=%b PIX=%h, required 0 1 0 0 0 000000",
                         LEVEL, BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE, DSP_PIX);
    end
    DSP_preDE = 0; DISPON = 0;
    #1 ARSTN = 1'b1;
    q.delete(); exp_over = 0; exp_under = 0;
    @(posedge ACLK); #1;
    idle();
    checks++;
    if (LEVEL !== '0 || BUF_WREADY !== 1'b1 || DSP_DE !== 1'b0) begin
      errors++; $display("FAIL arst_release: LEVEL=%0d WREADY=%b DE=%b, required 0 1 0", LEVEL, BUF_WREADY, DSP_DE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_concurrent();
    test_flush();
    test_blank();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
